pc_gen_pipe: RTL and testbench
==============================

// Module: pc_gen_pipe
// PURPOSE
//  Next-generation program-counter unit for the speedflow core. Holds the fetch PC, presents it
//  to instruction memory over a valid/ready handshake, and computes the next PC from pc_ctrl.
//  Adds stall gating, misaligned-target trapping, a post-redirect bubble and a taken-redirect counter.
//  Sits between decode/ALU (pc_ctrl, cond, rs1, imm) and the imem fetch port.
// PARAMETERS
//  XLEN          32            address/data width
//  RESET_ADDR    32'h8000_0000 PC loaded on reset
//  BUBBLE_EN_P   1             1: drop fetch_valid one cycle after any non-sequential PC change
//  CNT_W         16            width of saturating redirect counter
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     synchronous active-low reset
//  pc_ctrl        in   3     next-PC op, `PC_* codes from defs.sv: SNPC=0,J_pc=1,J_rs1=2,B=3,B_inv=4,EPC=5,TRAP=6,7=hold
//  ctrl_valid     in   1     pc_ctrl/operands valid this cycle
//  stall          in   1     pipeline stall; blocks PC update
//  cond           in   1     branch condition (|alu_out)
//  inst_is_c      in   1     current inst is 16-bit (used only with PC_COMPRESSED_EN)
//  rs1            in   XLEN  register operand
//  offset         in   XLEN  immediate
//  epc            in   XLEN  exception return address
//  mtvec          in   XLEN  trap vector
//  fetch_ready    in   1     imem accepts pc this cycle
//  fetch_valid    out  1     pc is a valid fetch request
//  pc             out  XLEN  current fetch PC
//  snpc           out  XLEN  pc + step (combinational)
//  misalign_o     out  1     one-cycle pulse: jump/branch target misaligned
//  misalign_addr  out  XLEN  offending target, held until next misalign
//  redirect_cnt   out  CNT_W count of non-sequential PC updates, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): pc=RESET_ADDR, state=BOOT, fetch_valid=0, misalign_o=0,
//   misalign_addr=0, redirect_cnt=0. Reset mid-operation overrides everything.
//  FSM: BOOT -> RUN (unconditional, 1 cycle). RUN: fetch_valid=1. BUBBLE: fetch_valid=0,
//   pc frozen, -> RUN next cycle. BUBBLE entered only if BUBBLE_EN_P=1.
//  fire = (state==RUN) & fetch_valid & fetch_ready & ctrl_valid & ~stall. PC changes only on fire.
//  fetch_valid=1 with fetch_ready=0: pc and fetch_valid held stable until accepted.
//  Target per op: SNPC->snpc; J_pc->pc+offset; J_rs1->(rs1+offset)&~1; B->cond?pc+offset:snpc;
//   B_inv->~cond?pc+offset:snpc; EPC->epc&~AMASK; TRAP->mtvec&~AMASK; 7->pc (no change, not counted).
//  All adds modulo 2^XLEN (wrap, no carry out). AMASK=3 (2'b11), or 1 with PC_COMPRESSED_EN.
//  Misalign: for J_pc/J_rs1/taken B/B_inv, if target&AMASK != 0 -> pc<=mtvec&~AMASK,
//   misalign_o=1 next cycle only, misalign_addr<=target; counts as redirect.
//  Redirect = fire and next pc != snpc (incl. taken branch, jump, EPC, TRAP, misalign).
//   Redirect: redirect_cnt+=1, saturates at all-ones; state->BUBBLE if BUBBLE_EN_P.
//  Jump/branch with target == snpc: treated as sequential (no bubble, no count).
//  stall and ctrl_valid=0 are equivalent: hold; misalign_o stays 0.
// CONFIGURATION
//  PC_COMPRESSED_EN defined: step = inst_is_c ? 2 : 4; AMASK=1 (2-byte alignment).
//  Not defined: step = 4; AMASK=3; inst_is_c ignored; target bit1 set -> misalign.
// TESTING
//  Reset, fetch_ready=1, ctrl SNPC x3 -> fetch_valid 0 then 1; pc 0x80000000,..04,..08,..0C.
//  pc=0x80000010, J_pc offset=0x20 -> pc=0x80000030, one bubble cycle, redirect_cnt=1.
//  pc=0x100, B cond=0 offset=0x40 -> pc=0x104, no bubble; B_inv cond=0 -> pc=0x144.
//  J_rs1 rs1=0x203 offset=0 (no macro) -> target 0x202 misaligned: pc=mtvec, misalign_o pulse, addr=0x202.
//  fetch_ready=0 for 3 cycles with SNPC -> pc, fetch_valid stable; stall=1 -> no update.
//  CNT_W=2, 5 redirects -> redirect_cnt=3; PC_COMPRESSED_EN, inst_is_c=1 at 0x100 -> pc=0x102.

Source files
------------

// File: rtl/pc_gen_pipe_if.sv
// Fetch-port bundle between the PC generator (master) and instruction memory (slave).
interface pc_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] snpc;

  modport master (output fetch_valid, output pc, output snpc, input fetch_ready);
  modport slave  (input fetch_valid, input pc, input snpc, output fetch_ready);
endinterface

// File: rtl/pc_gen_pipe.sv
// Fetch PC generator: holds the PC, offers it over a valid/ready fetch port and picks the next PC.
// Optional build macro PC_COMPRESSED_EN enables 16-bit instruction stepping and 2-byte alignment.
module pc_gen_pipe #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_ADDR  = 32'h8000_0000,
  parameter bit              BUBBLE_EN_P = 1'b1,
  parameter int              CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        pc_ctrl,
  input  logic              ctrl_valid,
  input  logic              stall,
  input  logic              cond,
  input  logic              inst_is_c,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   offset,
  input  logic [XLEN-1:0]   epc,
  input  logic [XLEN-1:0]   mtvec,
  pc_gen_pipe_if.master     fetch_if,
  output logic              misalign_o,
  output logic [XLEN-1:0]   misalign_addr,
  output logic [CNT_W-1:0]  redirect_cnt
);

  localparam logic [2:0] PC_SNPC  = 3'd0;
  localparam logic [2:0] PC_J_PC  = 3'd1;
  localparam logic [2:0] PC_J_RS1 = 3'd2;
  localparam logic [2:0] PC_B     = 3'd3;
  localparam logic [2:0] PC_B_INV = 3'd4;
  localparam logic [2:0] PC_EPC   = 3'd5;
  localparam logic [2:0] PC_TRAP  = 3'd6;
  localparam logic [2:0] PC_HOLD  = 3'd7;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_BUBBLE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef PC_COMPRESSED_EN
  localparam logic [XLEN-1:0] AMASK = {{(XLEN-1){1'b0}}, 1'b1};
  logic [XLEN-1:0] step_s;
  assign step_s = inst_is_c ? {{(XLEN-2){1'b0}}, 2'b10} : {{(XLEN-3){1'b0}}, 3'b100};
`else
  localparam logic [XLEN-1:0] AMASK = {{(XLEN-2){1'b0}}, 2'b11};
  logic [XLEN-1:0] step_s;
  logic            unused_inst_is_c_s;
  assign step_s             = {{(XLEN-3){1'b0}}, 3'b100};
  assign unused_inst_is_c_s = inst_is_c;
`endif

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  snpc_s, br_tgt_s, tgt_s, next_pc_s;
  logic             chk_s, hold_s, misal_s, fire_s, redirect_s;

  assign snpc_s   = pc_q + step_s;
  assign br_tgt_s = pc_q + offset;

  // Target selection; chk_s marks control transfers whose target must be aligned.
  always_comb begin
    tgt_s  = snpc_s;
    chk_s  = 1'b0;
    hold_s = 1'b0;
    case (pc_ctrl)
      PC_SNPC:  tgt_s = snpc_s;
      PC_J_PC:  begin tgt_s = br_tgt_s; chk_s = 1'b1; end
      PC_J_RS1: begin tgt_s = (rs1 + offset) & ~{{(XLEN-1){1'b0}}, 1'b1}; chk_s = 1'b1; end
      PC_B:     begin tgt_s = cond ? br_tgt_s : snpc_s; chk_s = cond; end
      PC_B_INV: begin tgt_s = cond ? snpc_s : br_tgt_s; chk_s = ~cond; end
      PC_EPC:   tgt_s = epc & ~AMASK;
      PC_TRAP:  tgt_s = mtvec & ~AMASK;
      PC_HOLD:  begin tgt_s = pc_q; hold_s = 1'b1; end
      default:  begin tgt_s = pc_q; hold_s = 1'b1; end
    endcase
  end

  assign misal_s    = chk_s & (|(tgt_s & AMASK));
  assign next_pc_s  = misal_s ? (mtvec & ~AMASK) : tgt_s;
  assign fire_s     = (state_q == ST_RUN) & fetch_valid_q & fetch_if.fetch_ready & ctrl_valid & ~stall;
  // A jump landing on snpc is sequential; a misalign trap always counts.
  assign redirect_s = fire_s & ~hold_s & (misal_s | (next_pc_s != snpc_s));

  // Next-state, PC, counter and misalign capture.
  always_comb begin
    state_d = ST_BOOT;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    state_d = (redirect_s && BUBBLE_EN_P) ? ST_BUBBLE : ST_RUN;
      ST_BUBBLE: state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase

    if (fire_s) begin
      pc_d = next_pc_s;
    end else begin
      pc_d = pc_q;
    end

    if (redirect_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    misalign_d = fire_s & misal_s;
    if (fire_s && misal_s) begin
      misalign_addr_d = tgt_s;
    end else begin
      misalign_addr_d = misalign_addr_q;
    end

    fetch_valid_d = (state_d == ST_RUN);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_ADDR;
      fetch_valid_q   <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= {XLEN{1'b0}};
      cnt_q           <= {CNT_W{1'b0}};
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      fetch_valid_q   <= fetch_valid_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      cnt_q           <= cnt_d;
    end
  end

  assign fetch_if.fetch_valid = fetch_valid_q;
  assign fetch_if.pc          = pc_q;
  assign fetch_if.snpc        = snpc_s;
  assign misalign_o           = misalign_q;
  assign misalign_addr        = misalign_addr_q;
  assign redirect_cnt         = cnt_q;

endmodule

// File: tb/tb_pc_gen_pipe.sv
// Bench for pc_gen_pipe: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pc_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pc_ctrl;
  logic        ctrl_valid, stall, cond, inst_is_c, fetch_ready;
  logic [31:0] rs1, offset, epc, mtvec;

  logic        mis1, mis2;
  logic [31:0] maddr1, maddr2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen_pipe_if #(.XLEN(32)) f1 ();
  pc_gen_pipe_if #(.XLEN(32)) f2 ();
  assign f1.fetch_ready = fetch_ready;
  assign f2.fetch_ready = fetch_ready;

  pc_gen_pipe dut (
    .clk(clk), .rst_n(rst_n), .pc_ctrl(pc_ctrl), .ctrl_valid(ctrl_valid), .stall(stall),
    .cond(cond), .inst_is_c(inst_is_c), .rs1(rs1), .offset(offset), .epc(epc), .mtvec(mtvec),
    .fetch_if(f1), .misalign_o(mis1), .misalign_addr(maddr1), .redirect_cnt(cnt1)
  );

  pc_gen_pipe #(.CNT_W(2), .BUBBLE_EN_P(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pc_ctrl(pc_ctrl), .ctrl_valid(ctrl_valid), .stall(stall),
    .cond(cond), .inst_is_c(inst_is_c), .rs1(rs1), .offset(offset), .epc(epc), .mtvec(mtvec),
    .fetch_if(f2), .misalign_o(mis2), .misalign_addr(maddr2), .redirect_cnt(cnt2)
  );

  typedef struct {
    logic [31:0] pc;
    bit          boot;
    bit          bub;
    bit          mis;
    logic [31:0] maddr;
    int unsigned cnt;
  } mst_t;

  mst_t m [2];

  function automatic logic [31:0] m_step();
`ifdef PC_COMPRESSED_EN
    return inst_is_c ? 32'd2 : 32'd4;
`else
    return 32'd4;
`endif
  endfunction

  function automatic logic [31:0] m_amask();
`ifdef PC_COMPRESSED_EN
    return 32'd1;
`else
    return 32'd3;
`endif
  endfunction

  function automatic logic exp_fv(int k);
    return !m[k].boot && !m[k].bub;
  endfunction

  // Reference behaviour for one clock edge, from the architectural next-PC rules.
  function automatic mst_t mstep(mst_t s, bit bub_en, int unsigned cmax);
    mst_t n = s;
    logic [31:0] sn, tgt, npc, am;
    bit br, hold, mis;
    n.mis = 1'b0;
    if (!rst_n) begin
      n.pc = 32'h8000_0000; n.boot = 1'b1; n.bub = 1'b0; n.maddr = 32'd0; n.cnt = 0;
      return n;
    end
    if (s.boot) begin n.boot = 1'b0; return n; end
    if (s.bub)  begin n.bub  = 1'b0; return n; end
    if (!(fetch_ready && ctrl_valid && !stall)) return n;
    am = m_amask();
    sn = s.pc + m_step();
    br = 1'b0; hold = 1'b0; tgt = sn;
    case (pc_ctrl)
      3'd1: begin tgt = s.pc + offset; br = 1'b1; end
      3'd2: begin tgt = (rs1 + offset) & 32'hFFFF_FFFE; br = 1'b1; end
      3'd3: if (cond)  begin tgt = s.pc + offset; br = 1'b1; end
      3'd4: if (!cond) begin tgt = s.pc + offset; br = 1'b1; end
      3'd5: tgt = epc & ~am;
      3'd6: tgt = mtvec & ~am;
      3'd7: begin tgt = s.pc; hold = 1'b1; end
      default: tgt = sn;
    endcase
    mis = br && ((tgt & am) != 32'd0);
    npc = mis ? (mtvec & ~am) : tgt;
    n.pc  = npc;
    n.mis = mis;
    if (mis) n.maddr = tgt;
    if (!hold && (mis || npc != sn)) begin
      if (s.cnt < cmax) n.cnt = s.cnt + 1;
      n.bub = bub_en;
    end
    return n;
  endfunction

  task automatic tick();
    mst_t n0, n1;
    n0 = mstep(m[0], 1'b1, 65535);
    n1 = mstep(m[1], 1'b0, 3);
    @(posedge clk);
    m[0] = n0;
    m[1] = n1;
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic cv);
    pc_ctrl = op; ctrl_valid = cv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks += 5;
    if (f1.pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", f1.pc, 32'h8000_0000); end
    if (f1.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b expected 0", f1.fetch_valid); end
    if (cnt1 !== 16'd0)          begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt1); end
    if (mis1 !== 1'b0)           begin n_fail++; $display("FAIL reset_mis: got %b expected 0", mis1); end
    if (maddr1 !== 32'd0)        begin n_fail++; $display("FAIL reset_maddr: got %h expected 0", maddr1); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    fetch_ready = 1'b1; set_op(3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = 32'h8000_0000 + 32'(4 * i);
      n_checks += 3;
      if (f1.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv[%0d]: got %b expected 1", i, f1.fetch_valid); end
      if (f1.pc !== exp)           begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, f1.pc, exp); end
      if (f1.snpc !== exp + 32'd4) begin n_fail++; $display("FAIL seq_snpc[%0d]: got %h expected %h", i, f1.snpc, exp + 32'd4); end
    end
    tick();
  endtask

  task automatic test_jump_bubble();
    offset = 32'h20; set_op(3'd1, 1'b1);
    tick();
    n_checks += 3;
    if (f1.pc !== 32'h8000_0030) begin n_fail++; $display("FAIL jpc_pc: got %h expected %h", f1.pc, 32'h8000_0030); end
    if (f1.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL jpc_bubble: got %b expected 0", f1.fetch_valid); end
    if (cnt1 !== 16'd1)          begin n_fail++; $display("FAIL jpc_cnt: got %0d expected 1", cnt1); end
    set_op(3'd0, 1'b1);
    tick();
    n_checks += 2;
    if (f1.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL jpc_resume: got %b expected 1", f1.fetch_valid); end
    if (f1.pc !== 32'h8000_0030) begin n_fail++; $display("FAIL jpc_frozen: got %h expected %h", f1.pc, 32'h8000_0030); end
  endtask

  task automatic test_branch();
    mtvec = 32'h100; set_op(3'd6, 1'b1);
    tick();
    set_op(3'd0, 1'b0);
    tick();
    n_checks += 1;
    if (f1.pc !== 32'h100) begin n_fail++; $display("FAIL trap_pc: got %h expected 100", f1.pc); end
    cond = 1'b0; offset = 32'h40; set_op(3'd3, 1'b1);
    tick();
    n_checks += 3;
    if (f1.pc !== 32'h104)       begin n_fail++; $display("FAIL b_nt_pc: got %h expected 104", f1.pc); end
    if (f1.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL b_nt_nobubble: got %b expected 1", f1.fetch_valid); end
    if (cnt1 !== 16'd2)          begin n_fail++; $display("FAIL b_nt_cnt: got %0d expected 2", cnt1); end
    set_op(3'd4, 1'b1);
    tick();
    n_checks += 2;
    if (f1.pc !== 32'h144) begin n_fail++; $display("FAIL binv_pc: got %h expected 144", f1.pc); end
    if (cnt1 !== 16'd3)    begin n_fail++; $display("FAIL binv_cnt: got %0d expected 3", cnt1); end
    set_op(3'd0, 1'b0);
    tick();
  endtask

  task automatic test_misalign();
    mtvec = 32'h300; rs1 = 32'h203; offset = 32'h0; set_op(3'd2, 1'b1);
    tick();
    n_checks += 4;
    if (f1.pc !== 32'h300)   begin n_fail++; $display("FAIL mis_pc: got %h expected 300", f1.pc); end
    if (mis1 !== 1'b1)       begin n_fail++; $display("FAIL mis_pulse: got %b expected 1", mis1); end
    if (maddr1 !== 32'h202)  begin n_fail++; $display("FAIL mis_addr: got %h expected 202", maddr1); end
    if (cnt1 !== 16'd4)      begin n_fail++; $display("FAIL mis_cnt: got %0d expected 4", cnt1); end
    set_op(3'd0, 1'b0);
    tick();
    n_checks += 3;
    if (mis1 !== 1'b0)           begin n_fail++; $display("FAIL mis_clear: got %b expected 0", mis1); end
    if (maddr1 !== 32'h202)      begin n_fail++; $display("FAIL mis_hold: got %h expected 202", maddr1); end
    if (f1.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL mis_resume: got %b expected 1", f1.fetch_valid); end
  endtask

  task automatic test_backpressure();
    fetch_ready = 1'b0; set_op(3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks += 2;
      if (f1.pc !== 32'h300)       begin n_fail++; $display("FAIL bp_pc[%0d]: got %h expected 300", i, f1.pc); end
      if (f1.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL bp_fv[%0d]: got %b expected 1", i, f1.fetch_valid); end
    end
    fetch_ready = 1'b1; stall = 1'b1; set_op(3'd1, 1'b1); offset = 32'h6;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks += 2;
      if (f1.pc !== 32'h300) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected 300", i, f1.pc); end
      if (mis1 !== 1'b0)     begin n_fail++; $display("FAIL stall_mis[%0d]: got %b expected 0", i, mis1); end
    end
    stall = 1'b0; set_op(3'd0, 1'b1);
    tick();
    n_checks += 1;
    if (f1.pc !== 32'h304) begin n_fail++; $display("FAIL stall_release: got %h expected 304", f1.pc); end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    offset = 32'h20; set_op(3'd1, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) tick();
    n_checks += 4;
    if (cnt2 !== 2'd3)            begin n_fail++; $display("FAIL sat_cnt: got %0d expected 3", cnt2); end
    if (f2.pc !== 32'h8000_00A0)  begin n_fail++; $display("FAIL sat_pc: got %h expected %h", f2.pc, 32'h8000_00A0); end
    if (f2.fetch_valid !== 1'b1)  begin n_fail++; $display("FAIL sat_nobubble: got %b expected 1", f2.fetch_valid); end
    if (cnt1 !== 16'(m[0].cnt))   begin n_fail++; $display("FAIL sat_cnt_wide: got %0d expected %0d", cnt1, m[0].cnt); end
    set_op(3'd0, 1'b0);
    tick();
  endtask

`ifdef PC_COMPRESSED_EN
  task automatic test_compressed();
    mtvec = 32'h100; set_op(3'd6, 1'b1);
    tick();
    set_op(3'd0, 1'b0);
    tick();
    inst_is_c = 1'b1; set_op(3'd0, 1'b1);
    tick();
    n_checks += 1;
    if (f1.pc !== 32'h102) begin n_fail++; $display("FAIL comp_pc: got %h expected 102", f1.pc); end
    inst_is_c = 1'b0; set_op(3'd0, 1'b0);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 60) != 0);
      pc_ctrl     = 3'($urandom_range(0, 7));
      ctrl_valid  = ($urandom_range(0, 7) != 0);
      stall       = ($urandom_range(0, 5) == 0);
      fetch_ready = ($urandom_range(0, 4) != 0);
      cond        = 1'($urandom_range(0, 1));
      inst_is_c   = 1'($urandom_range(0, 1));
      rs1         = $urandom;
      offset      = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom_range(0, 255)) << 2);
      epc         = $urandom;
      mtvec       = $urandom;
      tick();
      n_checks += 8;
      if (f1.fetch_valid !== exp_fv(0))      begin n_fail++; $display("FAIL rnd_fv[%0d]: got %b expected %b", i, f1.fetch_valid, exp_fv(0)); end
      if (f1.pc !== m[0].pc)                 begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, f1.pc, m[0].pc); end
      if (f1.snpc !== m[0].pc + m_step())    begin n_fail++; $display("FAIL rnd_snpc[%0d]: got %h expected %h", i, f1.snpc, m[0].pc + m_step()); end
      if (mis1 !== m[0].mis)                 begin n_fail++; $display("FAIL rnd_mis[%0d]: got %b expected %b", i, mis1, m[0].mis); end
      if (maddr1 !== m[0].maddr)             begin n_fail++; $display("FAIL rnd_maddr[%0d]: got %h expected %h", i, maddr1, m[0].maddr); end
      if (cnt1 !== 16'(m[0].cnt))            begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, cnt1, m[0].cnt); end
      if (f2.pc !== m[1].pc)                 begin n_fail++; $display("FAIL rnd_pc2[%0d]: got %h expected %h", i, f2.pc, m[1].pc); end
      if (cnt2 !== 2'(m[1].cnt))             begin n_fail++; $display("FAIL rnd_cnt2[%0d]: got %0d expected %0d", i, cnt2, m[1].cnt); end
    end
  endtask

  initial begin
    m[0] = '{pc: 32'h8000_0000, boot: 1'b1, bub: 1'b0, mis: 1'b0, maddr: 32'd0, cnt: 0};
    m[1] = m[0];
    rst_n = 1'b0; pc_ctrl = 3'd0; ctrl_valid = 1'b0; stall = 1'b0; cond = 1'b0;
    inst_is_c = 1'b0; fetch_ready = 1'b0;
    rs1 = 32'd0; offset = 32'd0; epc = 32'd0; mtvec = 32'd0;
    #2;
    test_reset();
    test_sequential();
    test_jump_bubble();
    test_branch();
    test_misalign();
    test_backpressure();
    test_saturation();
`ifdef PC_COMPRESSED_EN
    test_compressed();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
